mem_bus_arbiter: RTL and testbench

- Shares the core's single SRAM-like memory bus between the instruction-fetch port (IF stage) and the data-access port (MEM stage).
- Grants one transaction at a time, sequences the address/data handshake with the bus slave, and returns results to the granted requester.
- Generates the fetch and memory stall signals consumed by the hazard logic.

---
 rtl/mem_bus_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one SRAM-like memory bus between the instruction
// fetch port and the data access port. One transaction is in flight at a
// time; the arbiter sequences the address phase (bus_req/bus_addr_ok) and
// the data phase (bus_data_ok) and returns the result to the granted port.
//
// Ports:
//   clk, rst                        clock, async active-high reset
//   inst_req/inst_addr              fetch request (held until inst_ok)
//   inst_rdata/inst_ok              fetch result, ok is a 1-cycle pulse
//   data_req/data_wr/data_wstrb/
//   data_addr/data_wdata            data request (held until data_ok)
//   data_rdata/data_ok              data result, ok is a 1-cycle pulse
//   bus_req/bus_wr/bus_wstrb/
//   bus_addr/bus_wdata              request to the bus slave
//   bus_addr_ok/bus_data_ok/
//   bus_rdata                       slave handshake and read data
//   istall/dstall                   stall flags for the hazard unit
//
// Bus-side outputs and the ok/rdata returns are decoded from the registered
// state and the slave handshake in the same cycle, so the earliest ok comes
// two cycles after the request is seen in IDLE.

module mem_bus_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    // fetch port
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_ok,
    // data port
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_ok,
    // bus slave
    output logic        bus_req,
    output logic        bus_wr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata,
    // hazard unit
    output logic        istall,
    output logic        dstall
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_IADDR = 3'd1,
        S_IDATA = 3'd2,
        S_DADDR = 3'd3,
        S_DDATA = 3'd4
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  starve_q;

    logic              pick_data_c;
    logic              pick_inst_c;

    // Arbitration: data wins unless fetch has waited out STARVE_LIMIT data grants.
    always_comb begin
        pick_data_c = data_req && !(inst_req && (starve_q == LIMIT));
        pick_inst_c = inst_req && !pick_data_c;
    end

    // State register and starvation counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            starve_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pick_data_c) begin
                        state_q <= S_DADDR;
                        // only data grants that overtake a waiting fetch count
                        if (inst_req && (starve_q < LIMIT)) begin
                            starve_q <= starve_q + CNT_W'(1);
                        end
                    end else if (pick_inst_c) begin
                        state_q  <= S_IADDR;
                        starve_q <= '0;
                    end
                end
                S_IADDR: begin
                    if (bus_addr_ok) begin
                        state_q <= S_IDATA;
                    end
                end
                S_IDATA: begin
                    if (bus_data_ok) begin
                        state_q <= S_IDLE;
                    end
                end
                S_DADDR: begin
                    if (bus_addr_ok) begin
                        state_q <= S_DDATA;
                    end
                end
                S_DDATA: begin
                    if (bus_data_ok) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Bus drive and result return, decoded from the granted state.
    // bus_data_ok outside a data state is ignored because no ok is decoded there.
    always_comb begin
        bus_req    = 1'b0;
        bus_wr     = 1'b0;
        bus_wstrb  = 4'h0;
        bus_addr   = 32'h0;
        bus_wdata  = 32'h0;
        inst_ok    = 1'b0;
        inst_rdata = 32'h0;
        data_ok    = 1'b0;
        data_rdata = 32'h0;
        case (state_q)
            S_IADDR: begin
                bus_req  = 1'b1;
                bus_addr = inst_addr;
            end
            S_IDATA: begin
                bus_addr = inst_addr;
                if (bus_data_ok) begin
                    inst_ok    = 1'b1;
                    inst_rdata = bus_rdata;
                end
            end
            S_DADDR: begin
                bus_req   = 1'b1;
                bus_wr    = data_wr;
                bus_wstrb = data_wstrb;
                bus_addr  = data_addr;
                bus_wdata = data_wdata;
            end
            S_DDATA: begin
                bus_wr    = data_wr;
                bus_wstrb = data_wstrb;
                bus_addr  = data_addr;
                bus_wdata = data_wdata;
                if (bus_data_ok) begin
                    data_ok    = 1'b1;
                    data_rdata = bus_rdata;
                end
            end
            default: begin
            end
        endcase
    end

    // Stall flags for the hazard unit.
    always_comb begin
        istall = inst_req & ~inst_ok;
        dstall = data_req & ~data_ok;
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a reactive bus slave with programmable wait
// states, requesters driven from tasks, and a scoreboard of expected grants
// and per-port transactions checked by a monitor every cycle.

module tb_mem_bus_arbiter;

    localparam int unsigned LIMIT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_ok;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_ok;
    logic        bus_req;
    logic        bus_wr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;
    logic        istall;
    logic        dstall;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_rdata(inst_rdata), .inst_ok(inst_ok),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_rdata(data_rdata), .data_ok(data_ok),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_wstrb(bus_wstrb),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
        .bus_rdata(bus_rdata),
        .istall(istall), .dstall(dstall)
    );

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } txn_t;

    txn_t inst_q[$];
    txn_t data_q[$];
    bit   grant_q[$];   // expected grant order, 1 = fetch, 0 = data

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    int          addr_wait = 0;
    int          data_wait = 0;
    bit          inject_dok = 0;
    int          sl_phase = 0;
    int          sl_cnt = 0;
    logic [31:0] sl_addr = 32'h0;

    int busreq_cyc, first_busreq_cyc, istall_cyc;
    int inst_ok_cnt, data_ok_cnt, last_ok_cyc;
    bit prev_ok = 0;

    function automatic logic [31:0] slave_rd(input logic [31:0] a);
        return (a == 32'hBFC0_0000) ? 32'h2408_0001 : (a ^ 32'h5A5A_0F0F);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    task automatic reset_stats();
        busreq_cyc = 0; first_busreq_cyc = -1; istall_cyc = 0;
        inst_ok_cnt = 0; data_ok_cnt = 0; last_ok_cyc = -1;
    endtask

    task automatic issue_inst(input logic [31:0] a);
        txn_t t;
        t.addr = a; t.wr = 1'b0; t.wstrb = 4'h0; t.wdata = 32'h0;
        inst_q.push_back(t);
        inst_addr = a;
        inst_req  = 1'b1;
    endtask

    task automatic issue_data(input logic w, input logic [3:0] s,
                              input logic [31:0] a, input logic [31:0] d);
        txn_t t;
        t.addr = a; t.wr = w; t.wstrb = s; t.wdata = d;
        data_q.push_back(t);
        data_wr = w; data_wstrb = s; data_addr = a; data_wdata = d;
        data_req = 1'b1;
    endtask

    // Per-cycle scoreboard check, called just after the slave drives its response.
    task automatic monitor();
        txn_t t;
        bit   g;
        vectors++;
        if (istall !== (inst_req & ~inst_ok)) begin
            miscompares++;
            $display("FAIL istall: got %b expected %b", istall, inst_req & ~inst_ok);
        end
        vectors++;
        if (dstall !== (data_req & ~data_ok)) begin
            miscompares++;
            $display("FAIL dstall: got %b expected %b", dstall, data_req & ~data_ok);
        end
        if (prev_ok) begin
            vectors++;
            if (bus_req !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_gap: bus_req got %b expected 0 after ok", bus_req);
            end
        end
        if (istall) istall_cyc++;
        if (bus_req) begin
            busreq_cyc++;
            if (busreq_cyc == 1) first_busreq_cyc = cyc;
            vectors++;
            if (grant_q.size() == 0) begin
                miscompares++;
                $display("FAIL bus_req_unexpected: got bus_req=1 expected 0");
            end else if (grant_q[0] && inst_q.size() > 0) begin
                t = inst_q[0];
                if ({bus_addr, bus_wr, bus_wstrb} !== {t.addr, 1'b0, 4'h0}) begin
                    miscompares++;
                    $display("FAIL bus_fetch_fields: got %h/%b/%b expected %h/0/0000",
                             bus_addr, bus_wr, bus_wstrb, t.addr);
                end
            end else if (!grant_q[0] && data_q.size() > 0) begin
                t = data_q[0];
                if ({bus_addr, bus_wr, bus_wstrb, bus_wdata} !==
                    {t.addr, t.wr, t.wstrb, t.wdata}) begin
                    miscompares++;
                    $display("FAIL bus_data_fields: got %h/%b/%b/%h expected %h/%b/%b/%h",
                             bus_addr, bus_wr, bus_wstrb, bus_wdata,
                             t.addr, t.wr, t.wstrb, t.wdata);
                end
            end
        end
        vectors++;
        if (inst_ok && data_ok) begin
            miscompares++;
            $display("FAIL ok_overlap: got inst_ok=1 data_ok=1 expected at most one");
        end
        if (inst_ok) begin
            inst_ok_cnt++; last_ok_cyc = cyc;
            if (grant_q.size() == 0 || inst_q.size() == 0) begin
                miscompares++;
                $display("FAIL inst_ok_spurious: got inst_ok=1 expected 0");
            end else begin
                g = grant_q.pop_front();
                t = inst_q.pop_front();
                vectors++;
                if (g !== 1'b1) begin
                    miscompares++;
                    $display("FAIL grant_order: got fetch expected data");
                end
                vectors++;
                if (inst_rdata !== slave_rd(t.addr)) begin
                    miscompares++;
                    $display("FAIL inst_rdata: got %h expected %h", inst_rdata, slave_rd(t.addr));
                end
            end
            inst_req = 1'b0;
        end
        if (data_ok) begin
            data_ok_cnt++; last_ok_cyc = cyc;
            if (grant_q.size() == 0 || data_q.size() == 0) begin
                miscompares++;
                $display("FAIL data_ok_spurious: got data_ok=1 expected 0");
            end else begin
                g = grant_q.pop_front();
                t = data_q.pop_front();
                vectors++;
                if (g !== 1'b0) begin
                    miscompares++;
                    $display("FAIL grant_order: got data expected fetch");
                end
                vectors++;
                if (data_rdata !== slave_rd(t.addr)) begin
                    miscompares++;
                    $display("FAIL data_rdata: got %h expected %h", data_rdata, slave_rd(t.addr));
                end
            end
            data_req = 1'b0;
        end
        prev_ok = inst_ok | data_ok;
    endtask

    // Bus slave: addr_ok after addr_wait stalled cycles, data_ok data_wait cycles later.
    initial begin
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;
        forever begin
            @(negedge clk);
            bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;
            if (sl_phase == 1) begin
                if (sl_cnt < data_wait) sl_cnt++;
                else begin
                    bus_data_ok = 1'b1; bus_rdata = slave_rd(sl_addr);
                    sl_phase = 0; sl_cnt = 0;
                end
            end else if (bus_req && !rst) begin
                if (sl_cnt < addr_wait) sl_cnt++;
                else begin
                    bus_addr_ok = 1'b1; sl_addr = bus_addr;
                    sl_phase = 1; sl_cnt = 0;
                end
            end
            if (inject_dok) begin
                bus_data_ok = 1'b1; bus_rdata = 32'hBAD0_BAD0; inject_dok = 0;
            end
            #1;
            if (!rst) monitor();
            else prev_ok = 0;
        end
    end

    task automatic wait_idle(input int budget, input string name);
        int t = 0;
        while ((inst_req || data_req || grant_q.size() != 0) && t < budget) begin
            @(posedge clk);
            t++;
        end
        vectors++;
        if (t >= budget) begin
            miscompares++;
            $display("FAIL %s_timeout: got %0d cycles expected < %0d", name, t, budget);
            inst_req = 1'b0; data_req = 1'b0;
            inst_q.delete(); data_q.delete(); grant_q.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        inst_req = 1'b0; inst_addr = 32'h0;
        data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'h0;
        data_addr = 32'h0; data_wdata = 32'h0;
        #2;
        vectors++;
        if ({bus_req, inst_ok, data_ok, bus_wr, bus_wstrb} !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b expected 00000000",
                     {bus_req, inst_ok, data_ok, bus_wr, bus_wstrb});
        end
        vectors++;
        if ({bus_addr, bus_wdata, inst_rdata, data_rdata} !== 128'h0) begin
            miscompares++;
            $display("FAIL reset_data: got %h/%h/%h/%h expected 0",
                     bus_addr, bus_wdata, inst_rdata, data_rdata);
        end
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_lone_fetch();
        int c0;
        addr_wait = 0; data_wait = 0;
        @(posedge clk); #1;
        reset_stats();
        c0 = cyc;
        grant_q.push_back(1'b1);
        issue_inst(32'hBFC0_0000);
        wait_idle(30, "lone_fetch");
        check_int("fetch_busreq_cycles", busreq_cyc, 1);
        check_int("fetch_busreq_at", first_busreq_cyc, c0 + 1);
        check_int("fetch_ok_at", last_ok_cyc, c0 + 2);
        check_int("fetch_ok_count", inst_ok_cnt, 1);
        check_int("fetch_istall_cycles", istall_cyc, 2);
    endtask

    task automatic test_lone_write();
        int c0;
        addr_wait = 2; data_wait = 0;
        @(posedge clk); #1;
        reset_stats();
        c0 = cyc;
        grant_q.push_back(1'b0);
        issue_data(1'b1, 4'b0011, 32'h8000_1000, 32'hDEAD_BEEF);
        wait_idle(30, "lone_write");
        check_int("write_busreq_cycles", busreq_cyc, 3);
        check_int("write_busreq_at", first_busreq_cyc, c0 + 1);
        check_int("write_ok_at", last_ok_cyc, c0 + 4);
        check_int("write_ok_count", data_ok_cnt, 1);
    endtask

    task automatic test_simultaneous();
        addr_wait = 0; data_wait = 1;
        @(posedge clk); #1;
        reset_stats();
        grant_q.push_back(1'b0);
        grant_q.push_back(1'b1);
        issue_inst(32'h0000_4000);
        issue_data(1'b0, 4'h0, 32'h8000_1100, 32'h0);
        wait_idle(40, "simultaneous");
        check_int("simul_inst_ok_count", inst_ok_cnt, 1);
        check_int("simul_data_ok_count", data_ok_cnt, 1);
    endtask

    task automatic test_starvation();
        addr_wait = 1; data_wait = 0;
        reset_stats();
        grant_q.push_back(1'b0); grant_q.push_back(1'b0); grant_q.push_back(1'b1);
        grant_q.push_back(1'b0); grant_q.push_back(1'b0); grant_q.push_back(1'b1);
        @(posedge clk);
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    int t = 0;
                    while (data_req && t < 100) begin @(posedge clk); t++; end
                    #1 issue_data(i[0], 4'hF, 32'h8000_2000 + 32'(i * 4), 32'h1111_0000 + 32'(i));
                end
            end
            begin
                for (int j = 0; j < 2; j++) begin
                    int t = 0;
                    while (inst_req && t < 100) begin @(posedge clk); t++; end
                    #1 issue_inst(32'h0000_8000 + 32'(j * 4));
                end
            end
        join
        wait_idle(200, "starvation");
        check_int("starve_inst_ok_count", inst_ok_cnt, 2);
        check_int("starve_data_ok_count", data_ok_cnt, 4);
    endtask

    task automatic test_spurious();
        addr_wait = 3; data_wait = 0;
        @(posedge clk); #1;
        reset_stats();
        inject_dok = 1;
        repeat (3) @(posedge clk);
        check_int("spur_idle_ok_count", inst_ok_cnt + data_ok_cnt, 0);
        check_int("spur_idle_busreq", busreq_cyc, 0);
        #1;
        grant_q.push_back(1'b0);
        issue_data(1'b0, 4'h0, 32'h8000_3000, 32'h0);
        @(posedge clk); #1;
        inject_dok = 1;
        @(negedge clk); #2;
        vectors++;
        if ({bus_req, data_ok} !== 2'b10) begin
            miscompares++;
            $display("FAIL spur_daddr: got bus_req,data_ok=%b expected 10", {bus_req, data_ok});
        end
        @(negedge clk); #2;
        vectors++;
        if (bus_req !== 1'b1) begin
            miscompares++;
            $display("FAIL spur_daddr_hold: got bus_req=%b expected 1", bus_req);
        end
        wait_idle(30, "spurious");
        check_int("spur_daddr_ok_count", data_ok_cnt, 1);
    endtask

    task automatic test_reset_mid();
        addr_wait = 0; data_wait = 4;
        @(posedge clk); #1;
        reset_stats();
        grant_q.push_back(1'b1);
        issue_inst(32'hBFC0_0100);
        @(posedge clk); #1;
        @(posedge clk); #2;
        vectors++;
        if ({bus_req, inst_ok, bus_addr} !== {2'b00, 32'hBFC0_0100}) begin
            miscompares++;
            $display("FAIL idata_before_reset: got %b/%h expected 00/bfc00100",
                     {bus_req, inst_ok}, bus_addr);
        end
        #1 rst = 1'b1;
        #1;
        vectors++;
        if ({bus_req, inst_ok, bus_addr, inst_rdata} !== 66'h0) begin
            miscompares++;
            $display("FAIL reset_mid: got %b/%h/%h expected 00/0/0",
                     {bus_req, inst_ok}, bus_addr, inst_rdata);
        end
        inst_req = 1'b0;
        inst_q.delete(); grant_q.delete();
        @(posedge clk); #2 rst = 1'b0;
        repeat (8) @(posedge clk);
        check_int("late_dok_ok_count", inst_ok_cnt + data_ok_cnt, 0);
        #1;
        vectors++;
        if ({bus_req, bus_addr} !== 33'h0) begin
            miscompares++;
            $display("FAIL post_reset_idle: got %b/%h expected 0/0", bus_req, bus_addr);
        end
    endtask

    initial begin
        test_reset();
        test_lone_fetch();
        test_lone_write();
        test_simultaneous();
        test_starvation();
        test_spurious();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before 500000");
        $fatal(1);
    end

endmodule
